// File: rtl/measure_scheduler.sv
// Multi-shot measurement sequencer: argmax per shot, per-outcome histogram, run-level mode.
// Define MEASURE_SCHED_SAT_EN to make histogram bins saturate instead of wrapping.
module measure_scheduler #(
   parameter int unsigned SHOTS_W = 8,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [SHOTS_W-1:0]   num_shots,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          state_real_flat,
   output logic                 res_valid,
   output logic [1:0]           res_result,
   output logic [4*CNT_W-1:0]   hist_flat,
   output logic [1:0]           mode_result,
   output logic                 busy,
   output logic                 done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [SHOTS_W-1:0] remaining_q, remaining_d;
   logic [CNT_W-1:0]   bins_q [4];
   logic [CNT_W-1:0]   bins_d [4];
   logic [1:0]         mode_q, mode_d;
   logic               done_q, done_d;
   logic               busy_q;
   logic               res_valid_q, res_valid_d;
   logic [1:0]         res_result_q, res_result_d;

   logic [7:0]         shot_max;
   logic [1:0]         shot_idx;
   logic [CNT_W-1:0]   mode_max;
   logic [1:0]         mode_idx;
   logic [CNT_W-1:0]   bin_inc;

   // Positive-only argmax: negative amplitudes never win, ties keep the lowest index.
   always_comb begin
      shot_max = '0;
      shot_idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (!state_real_flat[8*i+7] && (state_real_flat[8*i +: 8] > shot_max)) begin
            shot_max = state_real_flat[8*i +: 8];
            shot_idx = 2'(i);
         end
      end
   end

   always_comb begin
      mode_max = '0;
      mode_idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (bins_q[i] > mode_max) begin
            mode_max = bins_q[i];
            mode_idx = 2'(i);
         end
      end
   end

`ifdef MEASURE_SCHED_SAT_EN
   assign bin_inc = (bins_q[shot_idx] == '1) ? bins_q[shot_idx] : bins_q[shot_idx] + CNT_W'(1);
`else
   assign bin_inc = bins_q[shot_idx] + CNT_W'(1);
`endif

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      bins_d       = bins_q;
      mode_d       = mode_q;
      done_d       = 1'b0;
      res_valid_d  = 1'b0;
      res_result_d = res_result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               bins_d = '{default: '0};
               if (num_shots != '0) begin
                  remaining_d = num_shots;
                  state_d     = RUN;
               end else begin
                  state_d = FIN;
               end
            end
         end
         RUN: begin
            // Abort wins over a simultaneous handshake.
            if (abort) begin
               state_d = IDLE;
            end else if (in_valid) begin
               bins_d[shot_idx] = bin_inc;
               res_valid_d      = 1'b1;
               res_result_d     = shot_idx;
               remaining_d      = remaining_q - SHOTS_W'(1);
               if (remaining_q == SHOTS_W'(1)) begin
                  state_d = FIN;
               end
            end
         end
         FIN: begin
            mode_d  = mode_idx;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         remaining_q  <= '0;
         bins_q       <= '{default: '0};
         mode_q       <= '0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         res_valid_q  <= 1'b0;
         res_result_q <= '0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         bins_q       <= bins_d;
         mode_q       <= mode_d;
         done_q       <= done_d;
         busy_q       <= (state_d != IDLE);
         res_valid_q  <= res_valid_d;
         res_result_q <= res_result_d;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_hist
      assign hist_flat[CNT_W*g +: CNT_W] = bins_q[g];
   end

   assign in_ready    = (state_q == RUN);
   assign res_valid   = res_valid_q;
   assign res_result  = res_result_q;
   assign mode_result = mode_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule
